// File: rtl/ber_snapshot_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ber_snapshot_pkg : widths, FSM encodings and readout address map
// Revision: 1.0
// ------------------------------------------------------------------
package ber_snapshot_pkg;

    localparam int NB_COUNT = 64;
    localparam int NB_WORD  = 32;
    localparam int NB_ADDR  = 3;
    localparam int NB_STATE = 2;

    typedef logic [NB_STATE-1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CAPTURE = 2'd1;
    localparam state_t ST_READY   = 2'd2;

    localparam logic [NB_ADDR-1:0] ADDR_ERR_R_LO = 3'd0;
    localparam logic [NB_ADDR-1:0] ADDR_ERR_R_HI = 3'd1;
    localparam logic [NB_ADDR-1:0] ADDR_ERR_I_LO = 3'd2;
    localparam logic [NB_ADDR-1:0] ADDR_ERR_I_HI = 3'd3;
    localparam logic [NB_ADDR-1:0] ADDR_BIT_R_LO = 3'd4;
    localparam logic [NB_ADDR-1:0] ADDR_BIT_R_HI = 3'd5;
    localparam logic [NB_ADDR-1:0] ADDR_BIT_I_LO = 3'd6;
    localparam logic [NB_ADDR-1:0] ADDR_BIT_I_HI = 3'd7;

endpackage
`default_nettype wire

// File: rtl/ber_snapshot_edge_detect.sv
`default_nettype none
// ------------------------------------------------------------------
// edge_detect : 1-bit rising-edge detector with configurable reset value
// Revision: 1.0
// ------------------------------------------------------------------
module edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/ber_snapshot.sv
`default_nettype none
// ------------------------------------------------------------------
// ber_snapshot : coherent capture of four BER counters with word readout
// Revision: 1.0
// ------------------------------------------------------------------
module ber_snapshot
    import ber_snapshot_pkg::*;
#(
    parameter int NB_COUNT = ber_snapshot_pkg::NB_COUNT,
    parameter int NB_WORD  = ber_snapshot_pkg::NB_WORD,
    parameter int NB_ADDR  = ber_snapshot_pkg::NB_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NB_COUNT-1:0] i_error_count_r,
    input  logic [NB_COUNT-1:0] i_error_count_i,
    input  logic [NB_COUNT-1:0] i_bit_count_r,
    input  logic [NB_COUNT-1:0] i_bit_count_i,
    input  logic                i_snap_req,
    input  logic                i_rd_en,
    input  logic [NB_ADDR-1:0]  i_rd_addr,
    output logic [NB_WORD-1:0]  o_rd_data,
    output logic                o_rd_valid,
    output logic                o_snap_done,
    output logic [7:0]          o_snap_id
);

    state_t                state_q;
    state_t                state_d;
    logic                  snap_rise;
    logic                  capture_en;
    logic [NB_COUNT-1:0]   err_r_q;
    logic [NB_COUNT-1:0]   err_i_q;
    logic [NB_COUNT-1:0]   bit_r_q;
    logic [NB_COUNT-1:0]   bit_i_q;
    logic [2*NB_WORD-1:0]  sel_ext;
    logic [NB_WORD-1:0]    rd_data_q;
    logic [NB_WORD-1:0]    rd_data_d;
    logic                  rd_valid_q;
    logic [7:0]            snap_id_q;

    // Previous-value register resets high so a request held across reset is not an edge
    edge_detect #(
        .RST_VAL (1'b1)
    ) u_req_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (i_snap_req),
        .rise_o (snap_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (snap_rise) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_READY;
            ST_READY:   if (!i_snap_req) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        capture_en  = (state_q == ST_CAPTURE);
        o_snap_done = (state_q == ST_READY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r_q   <= '0;
            err_i_q   <= '0;
            bit_r_q   <= '0;
            bit_i_q   <= '0;
            snap_id_q <= '0;
        end else if (capture_en) begin
            err_r_q   <= i_error_count_r;
            err_i_q   <= i_error_count_i;
            bit_r_q   <= i_bit_count_r;
            bit_i_q   <= i_bit_count_i;
            snap_id_q <= snap_id_q + 8'd1;
        end
    end

    // Reads see the shadow as it was before this edge, even on a capture edge
    always_comb begin
        sel_ext = '0;
        case (i_rd_addr)
            ADDR_ERR_R_LO, ADDR_ERR_R_HI: sel_ext[NB_COUNT-1:0] = err_r_q;
            ADDR_ERR_I_LO, ADDR_ERR_I_HI: sel_ext[NB_COUNT-1:0] = err_i_q;
            ADDR_BIT_R_LO, ADDR_BIT_R_HI: sel_ext[NB_COUNT-1:0] = bit_r_q;
            ADDR_BIT_I_LO, ADDR_BIT_I_HI: sel_ext[NB_COUNT-1:0] = bit_i_q;
            default:                      sel_ext = '0;
        endcase
        rd_data_d = rd_data_q;
        if (i_rd_en) begin
            rd_data_d = i_rd_addr[0] ? sel_ext[2*NB_WORD-1:NB_WORD] : sel_ext[NB_WORD-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= i_rd_en;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_snap_id  = snap_id_q;

endmodule
`default_nettype wire

// File: tb/tb_ber_snapshot.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ber_snapshot : randomized and directed checks against a behavioural model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_ber_snapshot;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] err_r, err_i, bit_r, bit_i;
    logic        snap_req, rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid, snap_done;
    logic [7:0]  snap_id;

    always #5 clk = ~clk;

    ber_snapshot dut (
        .clk             (clk),
        .rst             (rst),
        .i_error_count_r (err_r),
        .i_error_count_i (err_i),
        .i_bit_count_r   (bit_r),
        .i_bit_count_i   (bit_i),
        .i_snap_req      (snap_req),
        .i_rd_en         (rd_en),
        .i_rd_addr       (rd_addr),
        .o_rd_data       (rd_data),
        .o_rd_valid      (rd_valid),
        .o_snap_done     (snap_done),
        .o_snap_id       (snap_id)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: shadow snapshot, capture count, and cycles since an accepted request edge
    logic [63:0] m_sh [4];
    int          m_id;
    int          m_age;
    logic        m_prev;
    logic [31:0] exp_data;
    logic        exp_valid, exp_done;
    bit          inc_mode = 1'b0;

    task automatic m_reset();
        for (int k = 0; k < 4; k++) m_sh[k] = 64'd0;
        m_id = 0; m_age = -1; m_prev = 1'b1;
        exp_data = 32'd0; exp_valid = 1'b0; exp_done = 1'b0;
    endtask

    function automatic logic [31:0] m_word(input int a);
        logic [63:0] v;
        v = m_sh[a / 2];
        return (a % 2 == 1) ? v[63:32] : v[31:0];
    endfunction

    task automatic cycle();
        if (rd_en) exp_data = m_word(int'(rd_addr));
        exp_valid = rd_en;
        if (m_age < 0) begin
            if (snap_req && !m_prev) m_age = 0;
        end else if (m_age == 0) begin
            m_sh[0] = err_r; m_sh[1] = err_i; m_sh[2] = bit_r; m_sh[3] = bit_i;
            m_id  = (m_id + 1) % 256;
            m_age = 1;
        end else if (!snap_req) begin
            m_age = -1;
        end
        m_prev   = snap_req;
        exp_done = (m_age >= 1);
        @(posedge clk); #1;
        if (inc_mode) begin
            err_r = err_r + 1; err_i = err_i + 1; bit_r = bit_r + 1; bit_i = bit_i + 1;
        end
    endtask

    task automatic apply_reset(input logic req);
        rst = 1'b0; snap_req = req; rd_en = 1'b0; rd_addr = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; snap_req = 1'b1; rd_en = 1'b0; rd_addr = 3'd0;
        err_r = {$urandom, $urandom}; err_i = {$urandom, $urandom};
        bit_r = {$urandom, $urandom}; bit_i = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", snap_done); end
        n_cmp++; if (snap_id !== 8'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", snap_id); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
        n_cmp++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rd_data); end
        m_reset();
        rst = 1'b1;
        repeat (4) cycle();
        n_cmp++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL held_req_done: got %b expected 0", snap_done); end
        n_cmp++; if (snap_id !== 8'd0) begin n_fail++; $display("FAIL held_req_id: got %0d expected 0", snap_id); end
        rd_en = 1'b1; rd_addr = 3'd0;
        cycle();
        rd_en = 1'b0;
        n_cmp++; if (rd_data !== 32'd0 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL held_req_read: got %h/%b expected 0/1", rd_data, rd_valid); end
    endtask

    task automatic test_capture_basic();
        logic [31:0] want [4];
        logic [2:0]  addrs [4];
        want[0] = 32'h2; want[1] = 32'h1; want[2] = 32'hFFFF_FFFF; want[3] = 32'hFF;
        addrs[0] = 3'd0; addrs[1] = 3'd1; addrs[2] = 3'd4; addrs[3] = 3'd5;
        err_r = 64'h0000_0001_0000_0002; bit_r = 64'h0000_00FF_FFFF_FFFF;
        err_i = 64'h0; bit_i = 64'h0;
        snap_req = 1'b0; cycle();
        snap_req = 1'b1; cycle();
        n_cmp++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early: got %b expected 0", snap_done); end
        cycle();
        n_cmp++; if (snap_done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", snap_done); end
        n_cmp++; if (snap_id !== 8'd1) begin n_fail++; $display("FAIL basic_id: got %0d expected 1", snap_id); end
        for (int k = 0; k < 4; k++) begin
            rd_en = 1'b1; rd_addr = addrs[k];
            cycle();
            n_cmp++; if (rd_data !== want[k] || rd_valid !== 1'b1) begin
                n_fail++; $display("FAIL basic_read addr %0d: got %h/%b expected %h/1", addrs[k], rd_data, rd_valid, want[k]); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        err_r = {$urandom, $urandom}; err_i = {$urandom, $urandom};
        bit_r = {$urandom, $urandom}; bit_i = {$urandom, $urandom};
        inc_mode = 1'b1;
        snap_req = 1'b0; cycle(); cycle();
        snap_req = 1'b1; cycle(); cycle();
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = 3'(a);
            cycle();
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin
                n_fail++; $display("FAIL b2b_read addr %0d: got %h/%b expected %h/1", a, rd_data, rd_valid, exp_data); end
        end
        rd_en = 1'b0;
        cycle();
        inc_mode = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== exp_data) begin
            n_fail++; $display("FAIL b2b_hold: got %h/%b expected %h/0", rd_data, rd_valid, exp_data); end
    endtask

    task automatic test_read_during_capture();
        apply_reset(1'b0);
        err_r = 64'd5; err_i = 64'd5; bit_r = 64'd5; bit_i = 64'd5;
        cycle();
        snap_req = 1'b1; cycle();
        rd_en = 1'b1; rd_addr = 3'd0;
        cycle();
        n_cmp++; if (rd_data !== 32'd0 || rd_data !== exp_data) begin
            n_fail++; $display("FAIL collide_old: got %h expected 0", rd_data); end
        cycle();
        n_cmp++; if (rd_data !== 32'd5 || rd_data !== exp_data) begin
            n_fail++; $display("FAIL collide_new: got %h expected 5", rd_data); end
        rd_en = 1'b0;
    endtask

    task automatic test_id_wrap();
        apply_reset(1'b0);
        cycle();
        for (int i = 0; i < 256; i++) begin
            err_r = {$urandom, $urandom};
            snap_req = 1'b1; cycle();
            snap_req = 1'b0; cycle(); cycle();
            n_cmp++; if (snap_id !== 8'((i + 1) % 256) || int'(snap_id) != m_id) begin
                n_fail++; $display("FAIL id_step %0d: got %0d expected %0d", i, snap_id, (i + 1) % 256); end
        end
        n_cmp++; if (snap_id !== 8'd0) begin n_fail++; $display("FAIL id_wrap: got %0d expected 0", snap_id); end
    endtask

    task automatic test_rise_in_ready();
        logic [63:0] a_val;
        a_val = {$urandom, $urandom};
        err_r = a_val;
        snap_req = 1'b1; cycle();
        snap_req = 1'b0; cycle();
        err_r = ~a_val;
        snap_req = 1'b1; cycle(); cycle(); cycle();
        n_cmp++; if (snap_id !== 8'd1 || int'(snap_id) != m_id) begin
            n_fail++; $display("FAIL ready_rise_id: got %0d expected 1", snap_id); end
        n_cmp++; if (snap_done !== 1'b1) begin n_fail++; $display("FAIL ready_rise_done: got %b expected 1", snap_done); end
        rd_en = 1'b1; rd_addr = 3'd0; cycle();
        rd_addr = 3'd1; cycle();
        n_cmp++; if (rd_data !== a_val[63:32]) begin
            n_fail++; $display("FAIL ready_rise_shadow: got %h expected %h", rd_data, a_val[63:32]); end
        rd_en = 1'b0; snap_req = 1'b0; cycle(); cycle();
        n_cmp++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL ready_exit: got %b expected 0", snap_done); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) snap_req = ~snap_req;
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 3'($urandom_range(0, 7));
            err_r = {$urandom, $urandom}; err_i = {$urandom, $urandom};
            bit_r = {$urandom, $urandom}; bit_i = {$urandom, $urandom};
            cycle();
            n_cmp++; if (rd_valid !== exp_valid || rd_data !== exp_data) begin
                n_fail++; $display("FAIL rand_read cyc %0d: got %h/%b expected %h/%b", c, rd_data, rd_valid, exp_data, exp_valid); end
            n_cmp++; if (snap_done !== exp_done || int'(snap_id) != m_id) begin
                n_fail++; $display("FAIL rand_state cyc %0d: got done %b id %0d expected done %b id %0d", c, snap_done, snap_id, exp_done, m_id); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_async_reset();
        err_r = {$urandom, $urandom} | 64'h1; err_i = {$urandom, $urandom};
        bit_r = {$urandom, $urandom} | 64'h1; bit_i = {$urandom, $urandom};
        snap_req = 1'b0; cycle(); cycle();
        snap_req = 1'b1; cycle(); cycle();
        rd_en = 1'b1; rd_addr = 3'd4; cycle();
        rd_en = 1'b0;
        n_cmp++; if (snap_done !== 1'b1 || rd_data !== bit_r[31:0]) begin
            n_fail++; $display("FAIL async_pre: got done %b data %h expected 1/%h", snap_done, rd_data, bit_r[31:0]); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (snap_done !== 1'b0 || snap_id !== 8'd0 || rd_data !== 32'd0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_clear: got done %b id %0d data %h valid %b expected all 0", snap_done, snap_id, rd_data, rd_valid); end
        @(posedge clk); #1;
        m_reset();
        rst = 1'b1;
        repeat (3) cycle();
        n_cmp++; if (snap_done !== 1'b0 || snap_id !== 8'd0) begin
            n_fail++; $display("FAIL async_idle: got done %b id %0d expected 0/0", snap_done, snap_id); end
        rd_en = 1'b1; rd_addr = 3'd4; cycle();
        rd_en = 1'b0;
        n_cmp++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL async_shadow: got %h expected 0", rd_data); end
    endtask

    initial begin
        test_reset();
        test_capture_basic();
        test_back_to_back();
        test_read_during_capture();
        test_id_wrap();
        test_rise_in_ready();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ber_snapshot.md
BER_SNAPSHOT -- requirements
Module: ber_snapshot

Interface
REQ-001 SHALL have parameter NB_COUNT, default 64: width of each BER counter input.
REQ-002 SHALL have parameter NB_WORD, default 32: readout word width.
REQ-003 SHALL have parameter NB_ADDR, default 3: readout word address width, giving 8 words.
REQ-004 SHALL have port clk, input, 1: single clock, shared with the DSP datapath; the block uses no other clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports i_error_count_r, i_error_count_i, i_bit_count_r, i_bit_count_i, input, NB_COUNT each: live counters from the dsp stage.
REQ-007 SHALL have port i_snap_req, input, 1: capture request level, toggled by firmware via GPIO.
REQ-008 SHALL have port i_rd_en, input, 1: readout strobe.
REQ-009 SHALL have port i_rd_addr, input, NB_ADDR: word select.
REQ-010 SHALL have port o_rd_data, output, NB_WORD: registered readout word.
REQ-011 SHALL have port o_rd_valid, output, 1: o_rd_data valid this cycle.
REQ-012 SHALL have port o_snap_done, output, 1: shadow holds a coherent capture.
REQ-013 SHALL have port o_snap_id, output, 8: capture sequence number.

Function
REQ-014 SHALL keep four NB_COUNT shadow registers, loaded together in one clk edge so all four values come from the same cycle.
REQ-015 SHALL detect a rising edge of i_snap_req using a registered copy of the previous value.
REQ-016 SHALL implement FSM states IDLE, CAPTURE and READY.
REQ-017 IDLE SHALL go to CAPTURE on a rising edge; CAPTURE SHALL last exactly 1 cycle, load the shadows and go to READY; READY SHALL go to IDLE when i_snap_req is low.
REQ-018 o_snap_done SHALL be 1 only in READY, i.e. from 2 cycles after the rising edge until 1 cycle after i_snap_req falls.
REQ-019 A rising edge seen in CAPTURE or READY SHALL be ignored; no re-capture without passing through IDLE.
REQ-020 o_snap_id SHALL increment by 1 on each CAPTURE and wrap from 255 to 0.
REQ-021 Readout SHALL have 1-cycle latency: i_rd_en at cycle N gives o_rd_data and o_rd_valid=1 at N+1.
REQ-022 With i_rd_en low, o_rd_valid SHALL be 0 and o_rd_data SHALL hold its last value.
REQ-023 The address map SHALL be: 0/1 error_r low/high, 2/3 error_i low/high, 4/5 bit_r low/high, 6/7 bit_i low/high.
REQ-024 Reads SHALL be allowed in every state and always return shadow contents, never live counters.
REQ-025 When a read and CAPTURE fall on the same edge, the read SHALL return the pre-capture shadow value.
REQ-026 Back-to-back reads SHALL be supported: one word per cycle, with no bubbles.

Reset
REQ-027 While rst=0, the block SHALL clear all shadows, o_rd_data, o_rd_valid, o_snap_done and o_snap_id to 0, and put the FSM in IDLE.
REQ-028 The previous-value register of i_snap_req SHALL reset to 1, so a request held high across reset release does not trigger a capture.
REQ-029 Reset asserted during CAPTURE or READY SHALL abort immediately, and no partial shadow load SHALL remain.

Structure
REQ-030 NB_COUNT, NB_WORD, NB_ADDR, the FSM state encodings and the address-map constants SHALL live in the shared DSP include/package.
REQ-031 The edge detector SHALL be a sub-module named edge_detect (1-bit, with reset value as a parameter); everything else SHALL stay flat.

Verification
REQ-032 Counters set to error_r=0x0000_0001_0000_0002, bit_r=0x0000_00FF_FFFF_FFFF; raise i_snap_req -> o_snap_done=1 two cycles later; reading addr 0,1,4,5 returns 0x2, 0x1, 0xFFFF_FFFF, 0xFF.
REQ-033 Counters incrementing every cycle; capture, then read all 8 words back-to-back -> o_rd_valid high for 8 consecutive cycles and values match the counters at the CAPTURE edge.
REQ-034 Read addr 0 on the same edge as CAPTURE, with old shadow 0 and new counters 5 -> returns 0; the next read of addr 0 returns 5.
REQ-035 Toggle i_snap_req 256 times -> o_snap_id goes 1..255 then 0; a second rising edge while in READY leaves o_snap_id and the shadows unchanged.
REQ-036 i_snap_req high through reset release -> no capture and o_snap_id=0; pull rst low mid-READY -> all outputs 0 asynchronously and FSM in IDLE.
